// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        StRun     = 1'b0,
        StMemWait = 1'b1
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_MEM_TIMEOUT = 64;
    localparam int unsigned DEF_TO_W        = 7;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// EX-stage forwarding select for one source operand; MEM result wins over WB.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic [4:0] i_wa_m,
    input  logic       i_rfwe_m,
    input  logic [4:0] i_wa_w,
    input  logic       i_rfwe_w,
    output logic [1:0] o_sel
);

    logic w_hit_m;
    logic w_hit_w;

    // $0 is hardwired, so a write to it is never a real producer.
    assign w_hit_m = i_rfwe_m & (i_wa_m != 5'd0) & (i_wa_m == i_src);
    assign w_hit_w = i_rfwe_w & (i_wa_w != 5'd0) & (i_wa_w == i_src);

    always_comb begin
        o_sel = FWD_RF;
        if (w_hit_m) begin
            o_sel = FWD_MEM;
        end else if (w_hit_w) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush priority, memory-wait FSM with timeout,
// operand forwarding selects and saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int unsigned TO_W        = DEF_TO_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_rs_d,
    input  logic [4:0]       i_rt_d,
    input  logic [4:0]       i_rs_e,
    input  logic [4:0]       i_rt_e,
    input  logic [4:0]       i_wa_e,
    input  logic             i_rfwe_e,
    input  logic             i_mtorf_sel_e,
    input  logic [4:0]       i_wa_m,
    input  logic             i_rfwe_m,
    input  logic [4:0]       i_wa_w,
    input  logic             i_rfwe_w,
    input  logic             i_branch_taken_e,
    input  logic             i_dm_access_m,
    input  logic             i_dm_rdy,
    output logic             o_stall_f,
    output logic             o_stall_d,
    output logic             o_stall_e,
    output logic             o_stall_m,
    output logic             o_flush_d,
    output logic             o_flush_e,
    output logic             o_flush_w,
    output logic [1:0]       o_forward_a_e,
    output logic [1:0]       o_forward_b_e,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [TO_W-1:0]  r_wait_cnt;
    logic [TO_W-1:0]  w_wait_cnt_nxt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_to_hit;
    logic             w_memwait;
    logic             w_lu;
    logic             w_branch_flush;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    assign w_to_hit  = (r_state == StMemWait) && (r_wait_cnt == TO_LAST);
    assign w_memwait = i_dm_access_m & ~i_dm_rdy & ~w_to_hit;
    assign w_lu      = i_mtorf_sel_e & i_rfwe_e & (i_wa_e != 5'd0) &
                       ((i_wa_e == i_rs_d) | (i_wa_e == i_rt_d));
    // A frozen EX holds the branch, so it re-fires once the memory wait releases.
    assign w_branch_flush = ~w_memwait & i_branch_taken_e;

    fwd_unit u_fwd_a (
        .i_src    (i_rs_e),
        .i_wa_m   (i_wa_m),
        .i_rfwe_m (i_rfwe_m),
        .i_wa_w   (i_wa_w),
        .i_rfwe_w (i_rfwe_w),
        .o_sel    (w_fwd_a)
    );

    fwd_unit u_fwd_b (
        .i_src    (i_rt_e),
        .i_wa_m   (i_wa_m),
        .i_rfwe_m (i_rfwe_m),
        .i_wa_w   (i_wa_w),
        .i_rfwe_w (i_rfwe_w),
        .o_sel    (w_fwd_b)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = '0;
        case (r_state)
            StRun: begin
                if (w_memwait) begin
                    w_state_nxt = StMemWait;
                end
            end
            StMemWait: begin
                if (w_memwait) begin
                    w_wait_cnt_nxt = r_wait_cnt + TO_W'(1);
                end else begin
                    w_state_nxt = StRun;
                end
            end
            default: w_state_nxt = StRun;
        endcase
    end

    always_comb begin
        o_stall_f     = 1'b0;
        o_stall_d     = 1'b0;
        o_stall_e     = 1'b0;
        o_stall_m     = 1'b0;
        o_flush_d     = 1'b0;
        o_flush_e     = 1'b0;
        o_flush_w     = 1'b0;
        o_forward_a_e = FWD_RF;
        o_forward_b_e = FWD_RF;
        if (!i_rst_n) begin
            o_flush_d = 1'b1;
            o_flush_e = 1'b1;
            o_flush_w = 1'b1;
        end else begin
            if (w_memwait) begin
                o_stall_f = 1'b1;
                o_stall_d = 1'b1;
                o_stall_e = 1'b1;
                o_stall_m = 1'b1;
                o_flush_w = 1'b1;
            end else begin
                if (w_branch_flush) begin
                    o_flush_d = 1'b1;
                    o_flush_e = 1'b1;
                end else if (w_lu) begin
                    o_stall_f = 1'b1;
                    o_stall_d = 1'b1;
                    o_flush_e = 1'b1;
                end
                // Timed-out load data must never reach the register file.
                if (w_to_hit) begin
                    o_flush_w = 1'b1;
                end
            end
            o_forward_a_e = w_fwd_a;
            o_forward_b_e = w_fwd_b;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StRun;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_to_hit) begin
                r_mem_err <= 1'b1;
            end
            if (o_stall_f && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_branch_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_mem_err   = r_mem_err;
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl (CNT_W=8, MEM_TIMEOUT=4).
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 8;
    localparam int unsigned TO = 4;
    localparam int unsigned TW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    rs_d, rt_d, rs_e, rt_e, wa_e, wa_m, wa_w;
    logic          rfwe_e, ld_e, rfwe_m, rfwe_w, br, dm_acc, dm_rdy;
    logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic [1:0]    fwd_a, fwd_b;
    logic          mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    // exp layout: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,FwdA[1:0],FwdB[1:0]}
    typedef struct {
        string       name;
        logic [4:0]  rs_d, rt_d, rs_e, rt_e, wa_e;
        logic        rfwe_e, ld_e;
        logic [4:0]  wa_m;
        logic        rfwe_m;
        logic [4:0]  wa_w;
        logic        rfwe_w;
        logic        br;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .CNT_W       (CW),
        .MEM_TIMEOUT (TO),
        .TO_W        (TW)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_rs_d           (rs_d),
        .i_rt_d           (rt_d),
        .i_rs_e           (rs_e),
        .i_rt_e           (rt_e),
        .i_wa_e           (wa_e),
        .i_rfwe_e         (rfwe_e),
        .i_mtorf_sel_e    (ld_e),
        .i_wa_m           (wa_m),
        .i_rfwe_m         (rfwe_m),
        .i_wa_w           (wa_w),
        .i_rfwe_w         (rfwe_w),
        .i_branch_taken_e (br),
        .i_dm_access_m    (dm_acc),
        .i_dm_rdy         (dm_rdy),
        .o_stall_f        (stall_f),
        .o_stall_d        (stall_d),
        .o_stall_e        (stall_e),
        .o_stall_m        (stall_m),
        .o_flush_d        (flush_d),
        .o_flush_e        (flush_e),
        .o_flush_w        (flush_w),
        .o_forward_a_e    (fwd_a),
        .o_forward_b_e    (fwd_b),
        .o_mem_err        (mem_err),
        .o_stall_cnt      (stall_cnt),
        .o_flush_cnt      (flush_cnt)
    );

    function automatic logic [10:0] outs();
        return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, fwd_a, fwd_b};
    endfunction

    function automatic vec_t mk(string nm, logic [4:0] a_rs_d, logic [4:0] a_rt_d,
                                logic [4:0] a_rs_e, logic [4:0] a_rt_e, logic [4:0] a_wa_e,
                                logic a_we_e, logic a_ld, logic [4:0] a_wa_m, logic a_we_m,
                                logic [4:0] a_wa_w, logic a_we_w, logic a_br,
                                logic [10:0] a_exp);
        vec_t v;
        v.name = nm;     v.rs_d = a_rs_d; v.rt_d = a_rt_d; v.rs_e = a_rs_e; v.rt_e = a_rt_e;
        v.wa_e = a_wa_e; v.rfwe_e = a_we_e; v.ld_e = a_ld; v.wa_m = a_wa_m; v.rfwe_m = a_we_m;
        v.wa_w = a_wa_w; v.rfwe_w = a_we_w; v.br = a_br; v.exp = a_exp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_in();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0; wa_e = '0; wa_m = '0; wa_w = '0;
        rfwe_e = 0; ld_e = 0; rfwe_m = 0; rfwe_w = 0; br = 0; dm_acc = 0; dm_rdy = 0;
    endtask

    // Advance one clock and update the saturating counter model.
    task automatic tick(input logic exp_sf, input logic exp_bf);
        @(posedge clk);
        if (exp_sf && exp_stall < 255) exp_stall++;
        if (exp_bf && exp_flush < 255) exp_flush++;
        #2;
    endtask

    task automatic chk_cnt(input string nm);
        chk({nm, "_stallcnt"}, 32'(stall_cnt), 32'(exp_stall));
        chk({nm, "_flushcnt"}, 32'(flush_cnt), 32'(exp_flush));
    endtask

    initial begin
        clear_in();
        vecs.push_back(mk("idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11'b0000_000_00_00));
        vecs.push_back(mk("lu_rs",   5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 11'b1100_010_00_00));
        vecs.push_back(mk("lu_rt",   0, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 11'b1100_010_00_00));
        vecs.push_back(mk("lu_r0",   0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 11'b0000_000_00_00));
        vecs.push_back(mk("lu_nowe", 5, 0, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 11'b0000_000_00_00));
        vecs.push_back(mk("alu_dep", 5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 11'b0000_000_00_00));
        vecs.push_back(mk("br_lu",   5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 11'b0000_110_00_00));
        vecs.push_back(mk("br",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11'b0000_110_00_00));
        vecs.push_back(mk("fwd_mem", 0, 0, 7, 0, 0, 0, 0, 7, 1, 7, 1, 0, 11'b0000_000_10_00));
        vecs.push_back(mk("fwd_wb",  0, 0, 7, 0, 0, 0, 0, 7, 0, 7, 1, 0, 11'b0000_000_01_00));
        vecs.push_back(mk("fwd_mix", 0, 0, 4, 3, 0, 0, 0, 3, 1, 4, 1, 0, 11'b0000_000_01_10));
        vecs.push_back(mk("fwd_r0",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 11'b0000_000_00_00));
        vecs.push_back(mk("lu_fwd",  5, 0, 7, 0, 5, 1, 1, 7, 1, 0, 0, 0, 11'b1100_010_10_00));

        // Reset: outputs forced even with hazards and forwarding present.
        rs_d = 5; wa_e = 5; rfwe_e = 1; ld_e = 1; br = 1; rs_e = 7; wa_m = 7; rfwe_m = 1;
        #1;
        chk("rst_outs", 32'(outs()), 32'(11'b0000_111_00_00));
        chk("rst_memerr", 32'(mem_err), 32'd0);
        chk_cnt("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_in();
        rst_n = 1;
        @(posedge clk);
        #2;

        // Combinational vectors in RUN state.
        foreach (vecs[i]) begin
            rs_d = vecs[i].rs_d; rt_d = vecs[i].rt_d; rs_e = vecs[i].rs_e; rt_e = vecs[i].rt_e;
            wa_e = vecs[i].wa_e; rfwe_e = vecs[i].rfwe_e; ld_e = vecs[i].ld_e;
            wa_m = vecs[i].wa_m; rfwe_m = vecs[i].rfwe_m;
            wa_w = vecs[i].wa_w; rfwe_w = vecs[i].rfwe_w; br = vecs[i].br;
            #1;
            chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
            tick(vecs[i].exp[10], vecs[i].exp[6]);
            chk_cnt(vecs[i].name);
        end

        // Memory wait of 3 cycles with a pending branch that must be deferred.
        clear_in();
        dm_acc = 1; br = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("memwait_c%0d", c), 32'(outs()), 32'(11'b1111_001_00_00));
            tick(1'b1, 1'b0);
        end
        dm_rdy = 1;
        #1;
        chk("memwait_release", 32'(outs()), 32'(11'b0000_110_00_00));
        tick(1'b0, 1'b1);
        chk_cnt("memwait");
        clear_in();
        dm_acc = 1; dm_rdy = 1;
        #1;
        chk("rdy_entry_nostall", 32'(outs()), 32'(11'b0000_000_00_00));
        tick(1'b0, 1'b0);

        // Timeout: memory never responds.
        clear_in();
        dm_acc = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("to_wait_c%0d", c), 32'(outs()), 32'(11'b1111_001_00_00));
            tick(1'b1, 1'b0);
        end
        #1;
        chk("to_hit", 32'(outs()), 32'(11'b0000_001_00_00));
        chk("to_hit_memerr_pre", 32'(mem_err), 32'd0);
        tick(1'b0, 1'b0);
        chk("to_memerr_set", 32'(mem_err), 32'd1);
        chk_cnt("timeout");
        clear_in();
        #1;
        chk("to_after_run", 32'(outs()), 32'(11'b0000_000_00_00));
        repeat (3) tick(1'b0, 1'b0);
        chk("to_memerr_sticky", 32'(mem_err), 32'd1);

        // Asynchronous reset in the middle of a memory wait.
        dm_acc = 1;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        #1;
        rst_n = 0;
        exp_stall = 0;
        exp_flush = 0;
        #1;
        chk("arst_outs", 32'(outs()), 32'(11'b0000_111_00_00));
        chk("arst_memerr", 32'(mem_err), 32'd0);
        chk_cnt("arst");
        @(negedge clk);
        dm_rdy = 1;
        rst_n = 1;
        tick(1'b0, 1'b0);
        #1;
        chk("arst_back_run", 32'(outs()), 32'(11'b0000_000_00_00));

        // Stall counter saturation.
        clear_in();
        rs_d = 9; wa_e = 9; rfwe_e = 1; ld_e = 1;
        for (int c = 0; c < 1000; c++) begin
            tick(1'b1, 1'b0);
        end
        chk_cnt("sat");
        chk("sat_allones", 32'(stall_cnt), 32'hFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
